// File: rtl/gray_pkg.sv
// Shared Gray-code definitions: tracker state encoding and a width-generic
// Gray-to-binary decode reused by the tracker and by to_binary.
package gray_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } trk_state_e;

  localparam int GRAY_MAX_W = 32;

  // A zero-extended Gray word decodes to the zero-extended binary word, so
  // one max-width decoder serves any WIDTH <= GRAY_MAX_W; callers slice.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray_tracker.sv
// Tracks a Gray-coded position: decodes each enabled sample, classifies the
// move as stall / +1 / -1 / illegal, and keeps revolution and error counters.
module gray_tracker
  import gray_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8,
  parameter int REV_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [WIDTH-1:0]        gray,
  input  logic                    clear_err,
  output logic [WIDTH-1:0]        binary,
  output logic                    valid,
  output logic                    step_up,
  output logic                    step_down,
  output logic                    glitch,
  output logic                    error,
  output logic [ERR_W-1:0]        error_count,
  output logic signed [REV_W-1:0] revs
);

  localparam logic [WIDTH-1:0] POS_MAX = '1;
  localparam logic [ERR_W-1:0] CNT_MAX = '1;

  trk_state_e state_q, state_d;

  logic [GRAY_MAX_W-1:0] gray_ext, bin_ext;
  logic [WIDTH-1:0]      new_bin, delta;
  logic                  cap_c, up_c, down_c, glitch_c;

  logic [WIDTH-1:0]        binary_d;
  logic                    valid_d, error_d;
  logic [ERR_W-1:0]        error_count_d;
  logic signed [REV_W-1:0] revs_d;

  assign gray_ext = GRAY_MAX_W'(gray);
  assign bin_ext  = gray2bin(gray_ext);
  assign new_bin  = bin_ext[WIDTH-1:0];
  assign delta    = new_bin - binary;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    if (enable && state_q == ST_INIT) state_d = ST_TRACK;
  end

  // move classification; +1 wins when WIDTH=1 makes +1 and -1 coincide
  always_comb begin
    cap_c    = 1'b0;
    up_c     = 1'b0;
    down_c   = 1'b0;
    glitch_c = 1'b0;
    if (enable) begin
      if (state_q == ST_INIT)      cap_c    = 1'b1;
      else if (delta == WIDTH'(1)) up_c     = 1'b1;
      else if (delta == POS_MAX)   down_c   = 1'b1;
      else if (delta != '0)        glitch_c = 1'b1;
    end
  end

  always_comb begin
    binary_d      = binary;
    valid_d       = valid;
    error_d       = error;
    error_count_d = error_count;
    revs_d        = revs;

    if (cap_c || up_c || down_c || glitch_c) binary_d = new_bin;
    if (cap_c) valid_d = 1'b1;

    if (up_c && binary == POS_MAX) revs_d = revs + REV_W'(1);
    if (down_c && binary == '0)    revs_d = revs - REV_W'(1);

    // a glitch coincident with clear_err counts as the first new error
    if (clear_err) begin
      error_d       = glitch_c;
      error_count_d = glitch_c ? ERR_W'(1) : '0;
    end else if (glitch_c) begin
      error_d = 1'b1;
      if (error_count != CNT_MAX) error_count_d = error_count + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      binary      <= '0;
      valid       <= 1'b0;
      step_up     <= 1'b0;
      step_down   <= 1'b0;
      glitch      <= 1'b0;
      error       <= 1'b0;
      error_count <= '0;
      revs        <= '0;
    end else begin
      binary      <= binary_d;
      valid       <= valid_d;
      step_up     <= up_c;
      step_down   <= down_c;
      glitch      <= glitch_c;
      error       <= error_d;
      error_count <= error_count_d;
      revs        <= revs_d;
    end
  end

endmodule

// File: tb/tb_gray_tracker.sv
// Directed bench for gray_tracker at WIDTH=4, ERR_W=8, REV_W=8.
module tb_gray_tracker;

  logic              clk = 1'b0;
  logic              reset, enable, clear_err;
  logic [3:0]        gray;
  logic [3:0]        binary;
  logic              valid, step_up, step_down, glitch, error;
  logic [7:0]        error_count;
  logic signed [7:0] revs;

  int n_cmp = 0;
  int n_bad = 0;

  gray_tracker #(.WIDTH(4), .ERR_W(8), .REV_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .gray(gray), .clear_err(clear_err),
    .binary(binary), .valid(valid), .step_up(step_up), .step_down(step_down),
    .glitch(glitch), .error(error), .error_count(error_count), .revs(revs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one enabled sample; returns #1 after the capturing edge
  task automatic smp(input logic [3:0] g, input logic clr = 1'b0);
    @(negedge clk);
    enable    = 1'b1;
    gray      = g;
    clear_err = clr;
    @(posedge clk);
    #1;
    enable    = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_pulses(input string tag, input logic [2:0] exp);
    chk(tag, {29'b0, step_up, step_down, glitch}, {29'b0, exp});
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear_err = 1'b0; gray = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_binary", binary, 0);
    chk("rst_valid", valid, 0);
    chk_pulses("rst_pulses", 3'b000);
    chk("rst_error", error, 0);
    chk("rst_count", error_count, 0);
    chk("rst_revs", $unsigned(revs), 0);
    reset = 1'b0;

    // capture then two up-steps
    smp(4'b0000);
    chk("cap_valid", valid, 1);
    chk("cap_binary", binary, 0);
    chk_pulses("cap_pulses", 3'b000);
    smp(4'b0001);
    chk_pulses("up1_pulses", 3'b100);
    chk("up1_binary", binary, 1);
    smp(4'b0011);
    chk_pulses("up2_pulses", 3'b100);
    chk("up2_binary", binary, 2);

    // wrap 15 -> 0 -> 15
    do_reset();
    smp(4'b1000);
    chk("cap15_binary", binary, 15);
    smp(4'b0000);
    chk_pulses("wrap_up_pulses", 3'b100);
    chk("wrap_up_binary", binary, 0);
    chk("wrap_up_revs", $unsigned(revs), 1);
    smp(4'b1000);
    chk_pulses("wrap_dn_pulses", 3'b010);
    chk("wrap_dn_binary", binary, 15);
    chk("wrap_dn_revs", $unsigned(revs), 0);

    // single-bit Gray change between non-adjacent positions
    do_reset();
    smp(4'b0001);
    smp(4'b1001);
    chk_pulses("gl_pulses", 3'b001);
    chk("gl_error", error, 1);
    chk("gl_count", error_count, 1);
    chk("gl_binary", binary, 14);
    chk("gl_revs", $unsigned(revs), 0);

    // stalls and disabled toggling
    for (int i = 0; i < 5; i++) begin
      smp(4'b1001);
      chk_pulses("stall_pulses", 3'b000);
      chk("stall_binary", binary, 14);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      gray = 4'(i * 5 + 3);
      @(posedge clk);
      #1;
      chk_pulses("dis_pulses", 3'b000);
      chk("dis_binary", binary, 14);
    end

    // saturation: alternating 1 <-> 14 is always illegal
    for (int i = 0; i < 300; i++) smp((i % 2 == 0) ? 4'b0001 : 4'b1001);
    chk("sat_count", error_count, 255);
    chk("sat_error", error, 1);
    smp(4'b0001, 1'b1);
    chk("clrgl_error", error, 1);
    chk("clrgl_count", error_count, 1);
    chk_pulses("clrgl_pulses", 3'b001);
    smp(4'b0001, 1'b1);
    chk("clr_error", error, 0);
    chk("clr_count", error_count, 0);

    // 20 up-steps, then reset mid-stream
    do_reset();
    smp(4'b0000);
    for (int i = 1; i <= 20; i++) begin
      logic [3:0] b;
      b = 4'(i);
      smp(b ^ (b >> 1));
      chk_pulses("cnt_pulses", 3'b100);
    end
    chk("cnt_binary", binary, 4);
    chk("cnt_revs", $unsigned(revs), 1);
    do_reset();
    chk("mid_rst_binary", binary, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_revs", $unsigned(revs), 0);
    chk_pulses("mid_rst_pulses", 3'b000);
    smp(4'b0100);
    chk("recap_valid", valid, 1);
    chk("recap_binary", binary, 7);
    chk_pulses("recap_pulses", 3'b000);

    // revolution counter wrap: 128 forward revs -> -128, one back -> +127
    do_reset();
    smp(4'b0000);
    for (int i = 1; i <= 16 * 128; i++) begin
      logic [3:0] b;
      b = 4'(i);
      smp(b ^ (b >> 1));
    end
    chk("revwrap_binary", binary, 0);
    chk("revwrap_pos", $unsigned(revs), 32'h80);
    smp(4'b1000);
    chk_pulses("revwrap_dn_pulses", 3'b010);
    chk("revwrap_neg", $unsigned(revs), 32'h7f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
